// File: rtl/hcms_display_ctrl.sv
// HCMS dot-matrix display controller: reset pulse, CW1/CW0 init, frame streaming via a byte-handshake sender.
// Optional HCMS_AUTO_REFRESH_EN adds a periodic frame refresh; otherwise frames are sent only on UPDATE_i.
module hcms_display_ctrl #(
    parameter int NUM_BYTES      = 20,
    parameter int RESET_CYCLES   = 16,
    parameter int REFRESH_PERIOD = 1000000
) (
    input  logic       CLK_i,
    input  logic       RST_i,
    input  logic       UPDATE_i,
    input  logic       CFG_i,
    input  logic [3:0] BRIGHT_i,
    input  logic [1:0] PEAK_i,
    output logic [7:0] MEM_ADDR_o,
    input  logic [7:0] MEM_DATA_i,
    output logic [7:0] TX_DATA_o,
    output logic       TX_LOAD_o,
    output logic       TX_CMD_o,
    output logic       TX_RESET_o,
    input  logic       TX_READY_i,
    output logic       INIT_DONE_o,
    output logic       BUSY_o
);

    localparam logic [2:0] S_RST_PULSE = 3'd0;
    localparam logic [2:0] S_CW1       = 3'd1;
    localparam logic [2:0] S_CW0       = 3'd2;
    localparam logic [2:0] S_IDLE      = 3'd3;
    localparam logic [2:0] S_FETCH     = 3'd4;
    localparam logic [2:0] S_LOAD      = 3'd5;
    localparam logic [2:0] S_WAIT_RDY  = 3'd6;
    localparam logic [2:0] S_WAIT_CLR  = 3'd7;

    localparam logic [1:0] K_CW1 = 2'd0;
    localparam logic [1:0] K_CW0 = 2'd1;
    localparam logic [1:0] K_DAT = 2'd2;

    localparam int              RC_W      = $clog2(RESET_CYCLES + 1);
    localparam logic [RC_W-1:0] RC_LAST   = RC_W'(RESET_CYCLES - 1);
    localparam logic [7:0]      ADDR_LAST = 8'(NUM_BYTES - 1);

    logic [2:0]      state_q, state_d;
    logic [RC_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [7:0]      addr_q, addr_d;
    logic [1:0]      kind_q, kind_d;
    logic            fetch_ph_q, fetch_ph_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_cmd_q, tx_cmd_d;
    logic            tx_load_q, tx_load_d;
    logic            init_done_q, init_done_d;
    logic            upd_pend_q, upd_pend_d;
    logic            cfg_pend_q, cfg_pend_d;
    logic            refresh_hit;
    logic            upd_req, cfg_req;

`ifdef HCMS_AUTO_REFRESH_EN
    localparam int              RF_W    = $clog2(REFRESH_PERIOD);
    localparam logic [RF_W-1:0] RF_LAST = RF_W'(REFRESH_PERIOD - 1);

    logic [RF_W-1:0] ref_cnt_q;

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            ref_cnt_q <= '0;
        end else if (init_done_q) begin
            ref_cnt_q <= (ref_cnt_q == RF_LAST) ? '0 : ref_cnt_q + 1'b1;
        end
    end

    assign refresh_hit = init_done_q && (ref_cnt_q == RF_LAST);
`else
    assign refresh_hit = 1'b0;
`endif

    // Same-cycle pulses count as pending so an idle controller reacts on the very next edge.
    assign upd_req = upd_pend_q | UPDATE_i;
    assign cfg_req = cfg_pend_q | CFG_i;

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        addr_d      = addr_q;
        kind_d      = kind_q;
        fetch_ph_d  = fetch_ph_q;
        tx_data_d   = tx_data_q;
        tx_cmd_d    = tx_cmd_q;
        tx_load_d   = tx_load_q;
        init_done_d = init_done_q;
        upd_pend_d  = upd_pend_q | UPDATE_i | refresh_hit;
        cfg_pend_d  = cfg_pend_q | CFG_i;

        case (state_q)
            S_RST_PULSE: begin
                if (rst_cnt_q == RC_LAST) begin
                    rst_cnt_d = '0;
                    state_d   = S_CW1;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            S_CW1: begin
                kind_d    = K_CW1;
                tx_data_d = 8'h80;
                tx_cmd_d  = 1'b1;
                tx_load_d = 1'b1;
                state_d   = S_LOAD;
            end
            S_CW0: begin
                kind_d    = K_CW0;
                tx_data_d = {1'b0, 1'b1, PEAK_i, BRIGHT_i};
                tx_cmd_d  = 1'b1;
                tx_load_d = 1'b1;
                state_d   = S_LOAD;
            end
            S_IDLE: begin
                if (cfg_req) begin
                    cfg_pend_d = 1'b0;
                    state_d    = S_CW0;
                end else if (upd_req) begin
                    upd_pend_d = refresh_hit;
                    fetch_ph_d = 1'b0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                // First cycle presents the address; read data is captured on the second.
                if (!fetch_ph_q) begin
                    fetch_ph_d = 1'b1;
                end else begin
                    fetch_ph_d = 1'b0;
                    kind_d     = K_DAT;
                    tx_data_d  = MEM_DATA_i;
                    tx_cmd_d   = 1'b0;
                    tx_load_d  = 1'b1;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (TX_READY_i) begin
                    tx_load_d = 1'b0;
                    state_d   = S_WAIT_CLR;
                end
            end
            S_WAIT_CLR: begin
                if (!TX_READY_i) begin
                    case (kind_q)
                        K_CW1: state_d = S_CW0;
                        K_CW0: begin
                            init_done_d = 1'b1;
                            if (!cfg_req && upd_req) begin
                                upd_pend_d = refresh_hit;
                                fetch_ph_d = 1'b0;
                                state_d    = S_FETCH;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                        default: begin
                            if (addr_q == ADDR_LAST) begin
                                addr_d  = 8'h00;
                                state_d = S_IDLE;
                            end else begin
                                addr_d  = addr_q + 8'h01;
                                state_d = S_FETCH;
                            end
                        end
                    endcase
                end
            end
            default: state_d = S_RST_PULSE;
        endcase
    end

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            state_q     <= S_RST_PULSE;
            rst_cnt_q   <= '0;
            addr_q      <= 8'h00;
            kind_q      <= K_CW1;
            fetch_ph_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_cmd_q    <= 1'b0;
            tx_load_q   <= 1'b0;
            init_done_q <= 1'b0;
            upd_pend_q  <= 1'b0;
            cfg_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            addr_q      <= addr_d;
            kind_q      <= kind_d;
            fetch_ph_q  <= fetch_ph_d;
            tx_data_q   <= tx_data_d;
            tx_cmd_q    <= tx_cmd_d;
            tx_load_q   <= tx_load_d;
            init_done_q <= init_done_d;
            upd_pend_q  <= upd_pend_d;
            cfg_pend_q  <= cfg_pend_d;
        end
    end

    assign MEM_ADDR_o  = addr_q;
    assign TX_DATA_o   = tx_data_q;
    assign TX_LOAD_o   = tx_load_q;
    assign TX_CMD_o    = tx_cmd_q;
    assign TX_RESET_o  = (state_q == S_RST_PULSE);
    assign INIT_DONE_o = init_done_q;
    assign BUSY_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_hcms_display_ctrl.sv
// Bench for hcms_display_ctrl: frame-buffer and serial-sender models, table-driven requests plus reset/overlap sequences.
module tb_hcms_display_ctrl;

    logic       clk = 1'b0;
    logic       rst, upd, cfg;
    logic [3:0] bright;
    logic [1:0] peak;
    logic [7:0] mem_addr, mem_data, tx_data;
    logic       tx_load, tx_cmd, tx_reset, tx_ready, init_done, busy;

    logic [7:0] mem [0:255];
    logic [8:0] q [$];
    logic       prev_load = 1'b0;
    logic       prev_busy = 1'b0;
    int         busy_starts = 0;
    int         rdy_cnt;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    hcms_display_ctrl #(.NUM_BYTES(20), .RESET_CYCLES(16), .REFRESH_PERIOD(100)) dut (
        .CLK_i(clk), .RST_i(rst), .UPDATE_i(upd), .CFG_i(cfg),
        .BRIGHT_i(bright), .PEAK_i(peak),
        .MEM_ADDR_o(mem_addr), .MEM_DATA_i(mem_data),
        .TX_DATA_o(tx_data), .TX_LOAD_o(tx_load), .TX_CMD_o(tx_cmd),
        .TX_RESET_o(tx_reset), .TX_READY_i(tx_ready),
        .INIT_DONE_o(init_done), .BUSY_o(busy)
    );

    always @(posedge clk) mem_data <= mem[mem_addr];

    // Sender raises READY 3 clocks after LOAD and drops it one clock after LOAD falls.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_ready <= 1'b0;
            rdy_cnt  <= 0;
        end else if (tx_load && !tx_ready) begin
            if (rdy_cnt == 2) begin
                tx_ready <= 1'b1;
                rdy_cnt  <= 0;
            end else begin
                rdy_cnt <= rdy_cnt + 1;
            end
        end else if (!tx_load) begin
            tx_ready <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (tx_load && !prev_load) q.push_back({tx_cmd, tx_data});
        if (busy && !prev_busy) busy_starts <= busy_starts + 1;
        prev_load <= tx_load;
        prev_busy <= busy;
    end

    typedef struct {
        logic       upd;
        logic       cfg;
        logic [3:0] br;
        logic [1:0] pk;
        int         n;
        logic [8:0] first;
        logic [8:0] last;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input string nm);
        int t = 0;
        while (busy && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk(nm, int'(busy), 0);
    endtask

    task automatic wait_bytes(input int base, input int n, input string nm);
        int t = 0;
        while (q.size() - base < n && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk(nm, int'(q.size() - base >= n), 1);
    endtask

    task automatic count_reset_pulse(input string nm, input bit pulse_upd);
        int n = 0;
        while (tx_reset && n < 100) begin
            if (pulse_upd && n == 3) upd = 1'b1;
            tick(1);
            upd = 1'b0;
            n++;
        end
        chk(nm, n, 16);
    endtask

    initial begin
        int base, bs, t, off;

        tbl[0] = '{1'b1, 1'b0, 4'hF, 2'd0, 20, 9'h010, 9'h023};
        tbl[1] = '{1'b1, 1'b1, 4'h3, 2'd2, 21, 9'h163, 9'h023};
        tbl[2] = '{1'b0, 1'b1, 4'h5, 2'd1,  1, 9'h155, 9'h155};
        tbl[3] = '{1'b0, 1'b1, 4'h0, 2'd3,  1, 9'h170, 9'h170};

        for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);
        rst = 1'b1; upd = 1'b0; cfg = 1'b0; bright = 4'hF; peak = 2'd0;
        tick(2);
        chk("rst tx_reset", int'(tx_reset), 1);
        chk("rst tx_load", int'(tx_load), 0);
        chk("rst tx_cmd", int'(tx_cmd), 0);
        chk("rst tx_data", int'(tx_data), 0);
        chk("rst mem_addr", int'(mem_addr), 0);
        chk("rst init_done", int'(init_done), 0);
        chk("rst busy", int'(busy), 1);

        base = q.size();
        rst = 1'b0;
        count_reset_pulse("init reset pulse length", 1'b0);
        t = 0;
        while (!init_done && t < 500) begin
            tick(1);
            t++;
        end
        chk("init done", int'(init_done), 1);
        chk("init byte count", q.size() - base, 2);
        chk("init cw1", int'(q[base]), 9'h180);
        chk("init cw0", int'(q[base + 1]), 9'h14F);
        tick(2);
        chk("idle after init", int'(busy), 0);

        for (int v = 0; v < 4; v++) begin
            base = q.size();
            bright = tbl[v].br;
            peak = tbl[v].pk;
            upd = tbl[v].upd;
            cfg = tbl[v].cfg;
            tick(1);
            upd = 1'b0;
            cfg = 1'b0;
            chk($sformatf("v%0d start latency", v), int'(busy), 1);
            wait_idle($sformatf("v%0d done", v));
            chk($sformatf("v%0d byte count", v), q.size() - base, tbl[v].n);
            chk($sformatf("v%0d first byte", v), int'(q[base]), int'(tbl[v].first));
            chk($sformatf("v%0d last byte", v), int'(q[base + tbl[v].n - 1]), int'(tbl[v].last));
            chk($sformatf("v%0d addr wrap", v), int'(mem_addr), 0);
            if (tbl[v].upd && q.size() - base == tbl[v].n) begin
                off = tbl[v].cfg ? 1 : 0;
                for (int k = 0; k < 20; k++)
                    chk($sformatf("v%0d data %0d", v, k), int'(q[base + off + k]), int'({1'b0, 8'(k + 16)}));
            end
        end

        bright = 4'hF;
        peak = 2'd0;
        base = q.size();
        bs = busy_starts;
        upd = 1'b1;
        tick(1);
        upd = 1'b0;
        wait_bytes(base, 6, "overlap reach byte 5");
        upd = 1'b1;
        tick(1);
        upd = 1'b0;
        wait_bytes(base, 40, "overlap two frames");
        wait_idle("overlap done");
        tick(50);
        chk("overlap byte count", q.size() - base, 40);
        chk("overlap frame starts", busy_starts - bs, 2);
        chk("overlap second frame first", int'(q[base + 20]), 9'h010);

        base = q.size();
        upd = 1'b1;
        tick(1);
        upd = 1'b0;
        wait_bytes(base, 8, "mid-frame reach byte 7");
        tick(1);
        chk("byte 7 loading", int'(tx_load), 1);
        #1 rst = 1'b1;
        #1;
        chk("async reset tx_load", int'(tx_load), 0);
        chk("async reset tx_reset", int'(tx_reset), 1);
        chk("async reset init_done", int'(init_done), 0);
        tick(2);
        rst = 1'b0;
        base = q.size();
        count_reset_pulse("rerun reset pulse length", 1'b1);
        t = 0;
        while (!init_done && t < 500) begin
            tick(1);
            t++;
        end
        chk("rerun init done", int'(init_done), 1);
        wait_idle("rerun pending frame done");
        chk("rerun byte count", q.size() - base, 22);
        chk("rerun cw1", int'(q[base]), 9'h180);
        chk("rerun cw0", int'(q[base + 1]), 9'h14F);
        chk("rerun frame first", int'(q[base + 2]), 9'h010);
        chk("rerun frame last", int'(q[base + 21]), 9'h023);

        bs = busy_starts;
        tick(250);
`ifdef HCMS_AUTO_REFRESH_EN
        chk("auto refresh frames", int'(busy_starts - bs >= 1), 1);
`else
        chk("no auto refresh frames", busy_starts - bs, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
